mod_dest_rx: RTL and testbench

//  Destination-side receiver for the serial data_out link driven by the source chain (src_a -> src_b -> tar).

---
 rtl/mod_dest_rx.sv | 107 ++++++++++
 tb/tb_mod_dest_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_dest_rx.sv
// Serial link receiver: frames start/data/even-parity/stop bits into WIDTH-bit words
// and queues good words in a DEPTH-entry FIFO behind a valid/ready interface.
module mod_dest_rx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bit_in,
    input  logic                       bit_vld,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_vld,
    input  logic                       dout_rdy,
    output logic                       par_err,
    output logic                       frame_err,
    output logic                       ovf,
    input  logic                       ovf_clr,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int CW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             par_bit;
    logic             stop_smp, par_bad, push_req, push, pop, full;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;

    always_comb begin
        state_nxt = state;
        if (bit_vld) begin
            case (state)
                IDLE:    if (bit_in) state_nxt = DATA;
                DATA:    if (cnt == CW'(WIDTH - 1)) state_nxt = PAR;
                PAR:     state_nxt = STOP;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // The stop bit is judged on the same edge it is sampled, so error pulses and
    // the push land one cycle after the stop bit.
    assign stop_smp = bit_vld && (state == STOP);
    assign par_bad  = par_bit != (^shreg);
    assign push_req = stop_smp && !par_bad && !bit_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            par_err   <= stop_smp && par_bad;
            frame_err <= stop_smp && !par_bad && bit_in;
            if (bit_vld) begin
                case (state)
                    IDLE: cnt <= '0;
                    DATA: begin
                        shreg[cnt] <= bit_in;
                        if (cnt != CW'(WIDTH - 1)) cnt <= cnt + CW'(1);
                    end
                    PAR:  par_bit <= bit_in;
                    default: ;
                endcase
            end
        end
    end

    assign full     = count == (AW + 1)'(DEPTH);
    assign dout_vld = count != '0;
    assign pop      = dout_vld && dout_rdy;
    // A pop frees the slot this same edge, so a full FIFO still accepts the push.
    assign push     = push_req && (!full || pop);
    assign dout     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: ;
            endcase
            if (push_req && !push) ovf <= 1'b1;
            else if (ovf_clr)      ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mod_dest_rx.sv
// Randomised and directed bench for mod_dest_rx against a queue-based frame/FIFO model.
module tb_mod_dest_rx;
    localparam int W = 8;
    localparam int D = 4;

    logic         clk, rst, bit_in, bit_vld, dout_rdy, ovf_clr;
    logic [W-1:0] dout;
    logic         dout_vld, par_err, frame_err, ovf;
    logic [2:0]   count;

    int n_cmp = 0, n_err = 0;
    bit rand_ctl = 0;

    mod_dest_rx #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld),
        .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
        .par_err(par_err), .frame_err(frame_err), .ovf(ovf),
        .ovf_clr(ovf_clr), .count(count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: collect the WIDTH+2 bits after a start bit, then judge the frame.
    logic         mbits[$];
    logic [W-1:0] mq[$];
    bit           mframe, movf, mpar, mfrm, model_on = 0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            mbits.delete(); mq.delete();
            mframe = 0; movf = 0; mpar = 0; mfrm = 0; model_on = 1;
        end else if (model_on) begin
            bit good, pop;
            logic [W-1:0] d;
            good = 0; mpar = 0; mfrm = 0; d = '0;
            pop = (mq.size() > 0) && dout_rdy;
            if (bit_vld) begin
                if (!mframe) begin
                    if (bit_in) begin mframe = 1; mbits.delete(); end
                end else begin
                    mbits.push_back(bit_in);
                    if (mbits.size() == W + 2) begin
                        for (int i = 0; i < W; i++) d[i] = mbits[i];
                        if (mbits[W] != ^d) mpar = 1;
                        else if (mbits[W+1]) mfrm = 1;
                        else good = 1;
                        mframe = 0;
                    end
                end
            end
            if (pop) void'(mq.pop_front());
            if (ovf_clr) movf = 0;
            if (good) begin
                if (mq.size() < D) mq.push_back(d);
                else movf = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (model_on && !rst) begin
            chk("dout_vld", dout_vld, mq.size() > 0);
            chk("count", count, mq.size());
            chk("par_err", par_err, mpar);
            chk("frame_err", frame_err, mfrm);
            chk("ovf", ovf, movf);
            if (mq.size() > 0) chk("dout", dout, mq[0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) begin
            bit_vld = 0;
            if (rand_ctl) begin
                dout_rdy = $urandom_range(0, 1);
                ovf_clr  = ($urandom_range(0, 15) == 0);
            end
            step();
        end
        bit_vld = 1; bit_in = b;
        if (rand_ctl) begin
            dout_rdy = $urandom_range(0, 1);
            ovf_clr  = ($urandom_range(0, 15) == 0);
        end
        step();
        bit_vld = 0; ovf_clr = 0;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic pflip, input logic stp, input int gap);
        send_bit(1'b1, gap);
        for (int i = 0; i < W; i++) send_bit(d[i], gap);
        send_bit((^d) ^ pflip, gap);
        send_bit(stp, gap);
    endtask

    initial begin
        rst = 1; bit_in = 0; bit_vld = 0; dout_rdy = 1; ovf_clr = 0;
        step(); step();
        rst = 0;
        chk("rst_dout", dout, 0);
        chk("rst_vld", dout_vld, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_errs", {par_err, frame_err}, 0);

        // 1: 0xA5 with rdy=1, visible for exactly one cycle
        send_frame(8'hA5, 0, 0, 0);
        chk("t1_dout", dout, 8'hA5);
        chk("t1_vld", dout_vld, 1);
        step();
        chk("t1_vld_after", dout_vld, 0);

        // 2: parity error
        send_frame(8'h3C, 1, 0, 0);
        chk("t2_par_err", par_err, 1);
        chk("t2_count", count, 0);
        step();
        chk("t2_par_pulse", par_err, 0);

        // 3: frame error then a good frame
        send_frame(8'h01, 0, 1, 0);
        chk("t3_frame_err", frame_err, 1);
        chk("t3_vld", dout_vld, 0);
        send_frame(8'h02, 0, 0, 0);
        chk("t3_dout", dout, 8'h02);

        // 4: overflow with consumer stalled, then drain in order
        step();
        dout_rdy = 0;
        for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 0, 0, 0);
        chk("t4_count", count, 4);
        chk("t4_ovf", ovf, 1);
        chk("t4_dout", dout, 8'h10);
        dout_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_pop", dout, 8'h10 + 8'(i));
            step();
        end
        chk("t4_empty", dout_vld, 0);
        ovf_clr = 1; step(); ovf_clr = 0;
        chk("t4_ovf_clr", ovf, 0);

        // 5: gapped frame, then back-to-back frames
        send_frame(8'h5A, 0, 0, 3);
        chk("t5_gap", dout, 8'h5A);
        step();
        dout_rdy = 0;
        send_frame(8'hC3, 0, 0, 0);
        send_frame(8'h7E, 0, 0, 0);
        chk("t5_b2b_count", count, 2);
        chk("t5_b2b_head", dout, 8'hC3);
        dout_rdy = 1; step(); step();

        // 6: reset mid-frame with two words queued
        dout_rdy = 0;
        send_frame(8'h33, 0, 0, 0);
        send_frame(8'h44, 0, 0, 0);
        send_bit(1, 0);
        for (int i = 0; i < 4; i++) send_bit(1, 0);
        rst = 1; step(); rst = 0;
        chk("t6_count", count, 0);
        chk("t6_vld", dout_vld, 0);
        chk("t6_errs", {par_err, frame_err}, 0);
        dout_rdy = 1;
        send_frame(8'hFF, 0, 0, 0);
        chk("t6_ff", dout, 8'hFF);

        // Random traffic: noise zeros while idle, gaps, bad frames, rdy/ovf_clr toggling
        rand_ctl = 1;
        for (int f = 0; f < 300; f++) begin
            int noise;
            noise = $urandom_range(0, 3);
            for (int k = 0; k < noise; k++) send_bit(0, $urandom_range(0, 1));
            send_frame(8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                       $urandom_range(0, 2));
        end
        rand_ctl = 0;
        dout_rdy = 1;
        repeat (6) step();
        chk("final_empty", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
